display_output_unit: RTL and testbench

- Downstream consumer of the control unit's displayWrite strobe (the OUTPUT-instruction path).
- On a write request it latches the datapath value and converts it from binary to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives registered, active-low seven-segment patterns with leading-zero blanking and an optional minus sign.
- Absorbs one back-to-back request in a single-entry pending buffer, so a write is never lost while a conversion is in progress.

---
 rtl/display_output_unit_if.sv | 40 ++++
 rtl/display_output_unit.sv | 198 +++++++++++++++++++
 tb/tb_display_output_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/display_output_unit_if.sv
// Display output bus: write request from the control unit and the driven
// seven-segment display state.
//
// Signals:
//   display_write  one-cycle write strobe (master -> slave)
//   data_in        value to display, sampled with display_write (master -> slave)
//   seg_out        DIGITS active-low 7-segment digits, digit i at [7i+6:7i],
//                  bit order {g,f,e,d,c,b,a} (slave -> master)
//   sign_out       sign digit, 7'h3F = minus, 7'h7F = blank (slave -> master)
//   busy           conversion or display update in progress (slave -> master)
//   done           one-cycle pulse on the update cycle (slave -> master)
interface display_output_unit_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  display_write;
  logic [WIDTH-1:0]      data_in;
  logic [7*DIGITS-1:0]   seg_out;
  logic [6:0]            sign_out;
  logic                  busy;
  logic                  done;

  modport master (
    output display_write,
    output data_in,
    input  seg_out,
    input  sign_out,
    input  busy,
    input  done
  );

  modport slave (
    input  display_write,
    input  data_in,
    output seg_out,
    output sign_out,
    output busy,
    output done
  );
endinterface

// File: rtl/display_output_unit.sv
// Display output unit: latches a value on a write strobe, converts its
// magnitude to BCD with a sequential shift-add-3 engine (one bit per cycle)
// and drives registered active-low seven-segment digits with leading-zero
// blanking and an optional minus sign. One request arriving while busy is
// held in a single-entry pending buffer (newest wins).
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset; aborts a conversion and blanks
//          the display
//   bus    display_output_unit_if slave modport (display_write, data_in,
//          seg_out, sign_out, busy, done)
//
// Parameters:
//   WIDTH   data width of data_in
//   DIGITS  decimal digits driven; 10**DIGITS must exceed 2**WIDTH-1
//   SIGNED  1: data_in is two's complement and drives the minus sign
module display_output_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  display_output_unit_if.slave  bus
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StUpdate
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                pend_q, pend_d;
  logic [WIDTH-1:0]    pend_val_q, pend_val_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [6:0]          sign_q, sign_d;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg_enc(input logic [3:0] digit);
    logic [6:0] pat;
    unique case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Value to convert: the pending entry has priority over a fresh strobe.
  logic [WIDTH-1:0] capture_val;
  logic             capture_neg;
  logic [WIDTH-1:0] capture_mag;

  always_comb begin
    capture_val = pend_q ? pend_val_q : bus.data_in;
    capture_neg = SIGNED && capture_val[WIDTH-1];
    // Negating the most negative value wraps to itself, which read as
    // unsigned is exactly its magnitude.
    capture_mag = capture_neg ? (-capture_val) : capture_val;
  end

  // Add-3 correction applied to every BCD nibble before each shift.
  logic [BcdW-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment image of the finished BCD result; digits above the most
  // significant non-zero digit are blanked, digit 0 is always shown.
  logic [7*DIGITS-1:0] seg_new;
  logic                leading;
  logic [3:0]          nib;

  always_comb begin
    seg_new = '0;
    leading = 1'b1;
    nib     = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      if (leading && (nib == 4'd0) && (i != 0)) begin
        seg_new[7*i +: 7] = 7'h7F;
      end else begin
        leading           = 1'b0;
        seg_new[7*i +: 7] = seg_enc(nib);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    seg_d      = seg_q;
    sign_d     = sign_q;

    unique case (state_q)
      StIdle: begin
        if (pend_q || bus.display_write) begin
          shift_d = capture_mag;
          bcd_d   = '0;
          cnt_d   = CntW'(WIDTH);
          neg_d   = capture_neg;
          state_d = StConv;
        end
        // A strobe landing on the cycle the pending entry launches would
        // otherwise be lost, so it becomes the new pending entry.
        pend_d = pend_q & bus.display_write;
        if (pend_q && bus.display_write) begin
          pend_val_d = bus.data_in;
        end
      end

      StConv: begin
        bcd_d   = {bcd_adj[BcdW-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StUpdate;
        end
      end

      StUpdate: begin
        seg_d   = seg_new;
        sign_d  = neg_q ? 7'h3F : 7'h7F;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // The in-flight conversion is untouched; a new request only lands in
    // the pending buffer, overwriting any older one.
    if ((state_q != StIdle) && bus.display_write) begin
      pend_d     = 1'b1;
      pend_val_d = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      seg_q      <= {DIGITS{7'h7F}};
      sign_q     <= 7'h7F;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      seg_q      <= seg_d;
      sign_q     <= sign_d;
    end
  end

  assign bus.seg_out  = seg_q;
  assign bus.sign_out = sign_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StUpdate);

endmodule

// File: tb/tb_display_output_unit.sv
// Bench for display_output_unit: a signed and an unsigned instance share one
// stimulus stream; a timing/arithmetic reference model predicts every output
// after every clock edge.
module tb_display_output_unit;

  localparam int unsigned W = 16;
  localparam int unsigned D = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  display_output_unit_if #(.WIDTH(W), .DIGITS(D)) bus_s ();
  display_output_unit_if #(.WIDTH(W), .DIGITS(D)) bus_u ();

  assign bus_u.display_write = bus_s.display_write;
  assign bus_u.data_in       = bus_s.data_in;

  display_output_unit #(.WIDTH(W), .DIGITS(D), .SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  display_output_unit #(.WIDTH(W), .DIGITS(D), .SIGNED(1'b0)) u_dut_u (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_u)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected display computed from the decimal value.
  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic logic [34:0] exp_seg(input logic [15:0] v, input bit sgn);
    int mag;
    int pw;
    logic [34:0] r;
    mag = (sgn && v[15]) ? (65536 - int'(v)) : int'(v);
    pw  = 1;
    r   = '0;
    for (int i = 0; i < int'(D); i++) begin
      if (i > 0 && mag < pw) r[7*i +: 7] = 7'h7F;
      else                   r[7*i +: 7] = digit_pat((mag / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_sign(input logic [15:0] v, input bit sgn);
    return (sgn && v[15]) ? 7'h3F : 7'h7F;
  endfunction

  // Model state: edge count, edge on which the running conversion started
  // (-1 when idle), pending request, and the displays currently expected.
  int          edge_n  = 0;
  int          start_e = -1;
  bit          pend    = 1'b0;
  logic [15:0] pend_val;
  logic [15:0] cur;
  logic [34:0] e_seg_s, e_seg_u;
  logic [6:0]  e_sign_s, e_sign_u;

  task automatic model_edge(input logic rst_v, input logic dw, input logic [15:0] din);
    edge_n++;
    if (rst_v) begin
      start_e  = -1;
      pend     = 1'b0;
      e_seg_s  = {5{7'h7F}};
      e_seg_u  = {5{7'h7F}};
      e_sign_s = 7'h7F;
      e_sign_u = 7'h7F;
    end else if (start_e < 0) begin
      if (pend) begin
        start_e = edge_n;
        cur     = pend_val;
        pend    = dw;
        if (dw) pend_val = din;
      end else if (dw) begin
        start_e = edge_n;
        cur     = din;
      end
    end else begin
      if (dw) begin
        pend     = 1'b1;
        pend_val = din;
      end
      // Display refreshes WIDTH+1 edges after the start.
      if (edge_n == start_e + int'(W) + 1) begin
        e_seg_s  = exp_seg(cur, 1'b1);
        e_sign_s = exp_sign(cur, 1'b1);
        e_seg_u  = exp_seg(cur, 1'b0);
        e_sign_u = exp_sign(cur, 1'b0);
        start_e  = -1;
      end
    end
  endtask

  task automatic compare_all();
    logic e_busy;
    logic e_done;
    e_busy = (start_e >= 0);
    e_done = (start_e >= 0) && (edge_n == start_e + int'(W));
    check_eq("seg_s",  bus_s.seg_out,  e_seg_s);
    check_eq("sign_s", bus_s.sign_out, e_sign_s);
    check_eq("seg_u",  bus_u.seg_out,  e_seg_u);
    check_eq("sign_u", bus_u.sign_out, e_sign_u);
    check_eq("busy_s", bus_s.busy, e_busy);
    check_eq("done_s", bus_s.done, e_done);
    check_eq("busy_u", bus_u.busy, e_busy);
    check_eq("done_u", bus_u.done, e_done);
  endtask

  task automatic cycle(input logic rst_v, input logic dw, input logic [15:0] din);
    reset               = rst_v;
    bus_s.display_write = dw;
    bus_s.data_in       = din;
    @(posedge clk);
    model_edge(rst_v, dw, din);
    #1;
    compare_all();
  endtask

  // Issue one request and run until the display refresh; counts busy cycles.
  task automatic run_value(input logic [15:0] v, output int busy_cycles);
    busy_cycles = 0;
    cycle(1'b0, 1'b1, v);
    if (bus_s.busy) busy_cycles++;
    for (int k = 0; k < 40 && !bus_s.done; k++) begin
      cycle(1'b0, 1'b0, 16'h0);
      if (bus_s.busy) busy_cycles++;
    end
    check_eq("done_seen", bus_s.done, 1'b1);
    cycle(1'b0, 1'b0, 16'h0);
  endtask

  int bc;

  initial begin
    reset               = 1'b1;
    bus_s.display_write = 1'b0;
    bus_s.data_in       = '0;

    // Reset state.
    repeat (3) cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("rst_seg",  bus_s.seg_out, {5{7'h7F}});
    check_eq("rst_sign", bus_s.sign_out, 7'h7F);
    check_eq("rst_busy", bus_s.busy, 1'b0);

    // Positive value, busy length.
    run_value(16'd1234, bc);
    check_eq("busy_len", bc, 17);
    check_eq("d1234_seg",  bus_s.seg_out, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
    check_eq("d1234_sign", bus_s.sign_out, 7'h7F);

    // Negative values and extremes.
    run_value(16'hFFF9, bc);
    check_eq("dm7_seg",  bus_s.seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});
    check_eq("dm7_sign", bus_s.sign_out, 7'h3F);
    run_value(16'h8000, bc);
    check_eq("dmin_seg",   bus_s.seg_out, {7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
    check_eq("dmin_sign",  bus_s.sign_out, 7'h3F);
    check_eq("u8000_seg",  bus_u.seg_out, {7'h30, 7'h24, 7'h78, 7'h02, 7'h00});
    check_eq("u8000_sign", bus_u.sign_out, 7'h7F);
    run_value(16'hFFFF, bc);
    check_eq("uffff_seg", bus_u.seg_out, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    check_eq("sffff_seg", bus_s.seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79});

    // Pending buffer: 42, then 5 and 9 while busy; 9 wins.
    cycle(1'b0, 1'b1, 16'd42);
    repeat (2) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'd5);
    repeat (2) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'd9);
    for (int k = 0; k < 40 && !bus_s.done; k++) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("p42_seg",   bus_s.seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
    check_eq("p_idle",    bus_s.busy, 1'b0);
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("p_restart", bus_s.busy, 1'b1);
    for (int k = 0; k < 40 && !bus_s.done; k++) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("p9_seg", bus_s.seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10});

    // Reset in the middle of a conversion.
    run_value(16'd77, bc);
    cycle(1'b0, 1'b1, 16'd9999);
    repeat (7) cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    check_eq("mr_seg",  bus_s.seg_out, {5{7'h7F}});
    check_eq("mr_busy", bus_s.busy, 1'b0);
    check_eq("mr_done", bus_s.done, 1'b0);
    repeat (20) cycle(1'b0, 1'b0, 16'h0);
    run_value(16'd0, bc);
    check_eq("zero_seg", bus_s.seg_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Randomized traffic, including a continuous-strobe stretch.
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        dw;
      logic [15:0] v;
      case ($urandom_range(0, 7))
        0:       v = 16'h0000;
        1:       v = 16'h8000;
        2:       v = 16'hFFFF;
        3:       v = 16'h7FFF;
        default: v = 16'($urandom);
      endcase
      dw = (n >= 1000 && n < 1100) ? 1'b1 : ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 599) == 0);
      cycle(r, dw, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
